limber_gnrl_fifo_rdport: RTL

//   Read-side port for the limber sync FIFO. Pops words from the FIFO read interface
//   (empty/ren/dout; dout combinational on the current read pointer).

---
 rtl/limber_gnrl_fifo_rdport.sv | 138 +++++++++++++
 1 files changed

// File: rtl/limber_gnrl_fifo_rdport.sv
// Read-side port for the limber sync FIFO: pops the FIFO into a 2-entry skid buffer
// and presents a registered valid/ready stream. Optional o_last burst marking: LIMBER_FIFO_RD_LAST_EN.
module limber_gnrl_fifo_rdport #(
  parameter int DW    = 8,
  parameter int BW    = 4,
  parameter int BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_dout,
  output logic          fifo_ren,
  input  logic          flush,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] o_data,
  output logic          o_last
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] head_data_q, head_data_d;
  logic [DW-1:0] skid_data_q, skid_data_d;
  logic          acc, pop;
  logic          head_ld_fifo, head_ld_skid, skid_ld;

  // The pop depends only on registered state and FIFO flags, never on o_ready.
  assign pop     = rst & ~fifo_empty & ~flush & (state_q != S_TWO);
  assign acc     = o_valid & o_ready;
  assign o_valid = (state_q != S_EMPTY);
  assign fifo_ren = pop;
  assign o_data  = head_data_q;

  always_comb begin
    state_d      = state_q;
    head_ld_fifo = 1'b0;
    head_ld_skid = 1'b0;
    skid_ld      = 1'b0;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (pop) begin
            state_d      = S_ONE;
            head_ld_fifo = 1'b1;
          end
        end
        S_ONE: begin
          if (pop && acc) begin
            head_ld_fifo = 1'b1;
          end else if (pop) begin
            state_d = S_TWO;
            skid_ld = 1'b1;
          end else if (acc) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (acc) begin
            state_d      = S_ONE;
            head_ld_skid = 1'b1;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    head_data_d = head_data_q;
    if (head_ld_fifo)
      head_data_d = fifo_dout;
    else if (head_ld_skid)
      head_data_d = skid_data_q;
    skid_data_d = skid_ld ? fifo_dout : skid_data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_EMPTY;
      head_data_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      skid_data_q <= skid_data_d;
    end
  end

`ifdef LIMBER_FIFO_RD_LAST_EN
  localparam logic [BW-1:0] CNT_MAX = BW'(BURST - 1);

  logic [BW-1:0] cnt_q, cnt_d;
  logic          pop_last;
  logic          head_last_q, head_last_d;
  logic          skid_last_q, skid_last_d;

  // Counter tracks the beat index of the next word to be popped.
  assign pop_last = (cnt_q == CNT_MAX);
  assign o_last   = head_last_q;

  always_comb begin
    cnt_d = cnt_q;
    if (flush)
      cnt_d = '0;
    else if (pop)
      cnt_d = pop_last ? '0 : cnt_q + BW'(1);
  end

  always_comb begin
    head_last_d = head_last_q;
    if (head_ld_fifo)
      head_last_d = pop_last;
    else if (head_ld_skid)
      head_last_d = skid_last_q;
    skid_last_d = skid_ld ? pop_last : skid_last_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      head_last_q <= 1'b0;
      skid_last_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      head_last_q <= head_last_d;
      skid_last_q <= skid_last_d;
    end
  end
`else
  assign o_last = 1'b0;
`endif

endmodule
